// File: rtl/demux_pkg.sv
// Shared definitions for the two-way registered demultiplexer:
// default widths and the occupancy encoding of each per-destination slot.
package demux_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// Two-entry FIFO owned by one demux destination. head_r always holds the
// oldest word, so data_out is a plain register and keeps its value once drained.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             valid
);

    slot_state_e      state_r;
    slot_state_e      state_nxt_s;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] tail_r;
    logic             full_s;
    logic             valid_s;
    logic             push_s;
    logic             pop_s;

    // A full slot refuses pushes even when it drains this cycle.
    assign push_s = push & ~full_s;
    assign pop_s  = pop & valid_s;

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Occupancy next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            EMPTY: begin
                if (push_s) state_nxt_s = ONE;
                else        state_nxt_s = EMPTY;
            end
            ONE: begin
                if (push_s && !pop_s)      state_nxt_s = FULL;
                else if (!push_s && pop_s) state_nxt_s = EMPTY;
                else                       state_nxt_s = ONE;
            end
            FULL: begin
                if (pop_s) state_nxt_s = ONE;
                else       state_nxt_s = FULL;
            end
            default: state_nxt_s = EMPTY;
        endcase
    end

    // Status flags decoded from the current occupancy.
    always_comb begin
        full_s  = 1'b0;
        valid_s = 1'b0;
        case (state_r)
            EMPTY: begin
                full_s  = 1'b0;
                valid_s = 1'b0;
            end
            ONE: begin
                full_s  = 1'b0;
                valid_s = 1'b1;
            end
            FULL: begin
                full_s  = 1'b1;
                valid_s = 1'b1;
            end
            default: begin
                full_s  = 1'b0;
                valid_s = 1'b0;
            end
        endcase
    end

    // Word storage; a pop from FULL shifts the younger word into the head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_r <= '0;
            tail_r <= '0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (push_s) head_r <= data_in;
                end
                ONE: begin
                    if (push_s && pop_s) head_r <= data_in;
                    else if (push_s)     tail_r <= data_in;
                end
                FULL: begin
                    if (pop_s) head_r <= tail_r;
                end
                default: begin
                    head_r <= head_r;
                end
            endcase
        end
    end

    assign data_out = head_r;
    assign valid    = valid_s;
    assign full     = full_s;

endmodule

// File: rtl/demux_reg.sv
// Registered 1-to-2 demultiplexer: routes each input word to destination A or B
// through a private two-entry slot and counts the words accepted per destination.
module demux_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_cnt,
    output logic [CNT_W-1:0] b_cnt
);

    localparam logic [CNT_W-1:0] CNT_INC = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             a_full_s;
    logic             b_full_s;
    logic             in_ready_s;
    logic             a_push_s;
    logic             b_push_s;
    logic [CNT_W-1:0] a_cnt_r;
    logic [CNT_W-1:0] b_cnt_r;

    // Readiness looks only at the selected slot's current occupancy, so the
    // downstream ready never reaches in_ready combinationally.
    always_comb begin
        in_ready_s = 1'b0;
        if (!rst_n) begin
            in_ready_s = 1'b0;
        end else if (in_sel) begin
            in_ready_s = ~b_full_s;
        end else begin
            in_ready_s = ~a_full_s;
        end
    end

    assign a_push_s = in_valid & in_ready_s & ~in_sel;
    assign b_push_s = in_valid & in_ready_s &  in_sel;

    demux_slot #(.WIDTH(WIDTH)) u_slot_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (a_push_s),
        .data_in  (in_data),
        .full     (a_full_s),
        .pop      (a_ready),
        .data_out (a_data),
        .valid    (a_valid)
    );

    demux_slot #(.WIDTH(WIDTH)) u_slot_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (b_push_s),
        .data_in  (in_data),
        .full     (b_full_s),
        .pop      (b_ready),
        .data_out (b_data),
        .valid    (b_valid)
    );

    // Per-destination accepted-word counters, wrapping naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_cnt_r <= '0;
            b_cnt_r <= '0;
        end else begin
            if (a_push_s) a_cnt_r <= a_cnt_r + CNT_INC;
            if (b_push_s) b_cnt_r <= b_cnt_r + CNT_INC;
        end
    end

    assign in_ready = in_ready_s;
    assign a_cnt    = a_cnt_r;
    assign b_cnt    = b_cnt_r;

endmodule
